// File: rtl/wb_arb_pkg.sv
// Shared constants and helpers for the Wishbone round-robin/fixed arbiter.
// The mode constants select the arbitration policy of wb_arb_rr.
package wb_arb_pkg;

    localparam logic ARB_MODE_RR    = 1'b1;
    localparam logic ARB_MODE_FIXED = 1'b0;

    localparam int WB_ARB_MAX_REQ = 16;
    localparam int WB_ARB_IDX_W   = $clog2(WB_ARB_MAX_REQ);

    // Encodes a one-hot (or zero) vector; with more than one bit set the result is the OR of indices.
    function automatic logic [WB_ARB_IDX_W-1:0] onehot_to_bin(input logic [WB_ARB_MAX_REQ-1:0] oh);
        logic [WB_ARB_IDX_W-1:0] b;
        b = '0;
        for (int i = 0; i < WB_ARB_MAX_REQ; i++) begin
            if (oh[i]) begin
                b = b | WB_ARB_IDX_W'(i);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational next-master picker: finds the first set bit of req_mask scanning upward
// from start (round robin) or from index 0 (fixed), wrapping inside 0..NREQ-1.
module wb_arb_pick
    import wb_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int GNT_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_mask,
    input  logic [GNT_W-1:0] start,
    input  logic             mode,
    output logic             found,
    output logic [GNT_W-1:0] idx
);

    logic [GNT_W-1:0]  base;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   first;
    logic [GNT_W-1:0]  ofs;
    logic [GNT_W:0]    pos;
    logic [GNT_W:0]    sum;

    always_comb begin
        base = (mode == ARB_MODE_RR) ? start : '0;
        dbl  = {req_mask, req_mask};
        rot  = '0;
        pos  = '0;
        // Reading the doubled vector from base rotates without touching codes >= NREQ.
        for (int i = 0; i < NREQ; i++) begin
            pos    = (GNT_W+1)'(i) + {1'b0, base};
            rot[i] = dbl[pos];
        end
        first = rot & (~rot + NREQ'(1));
        found = |rot;
        ofs   = GNT_W'(onehot_to_bin(WB_ARB_MAX_REQ'(first)));
        sum   = {1'b0, base} + {1'b0, ofs};
        if (sum >= (GNT_W+1)'(NREQ)) begin
            sum = sum - (GNT_W+1)'(NREQ);
        end
        idx = sum[GNT_W-1:0];
    end

endmodule

// File: rtl/wb_arb_rr.sv
// N-requester Wishbone bus arbiter with round-robin or fixed priority, an optional
// hold limit that forces rotation, and per-master lock that suppresses that preemption.
module wb_arb_rr
    import wb_arb_pkg::*;
#(
    parameter int   NREQ     = 4,
    parameter logic ARB_MODE = ARB_MODE_RR,
    parameter int   HOLD_MAX = 0,
    localparam int  GNT_W    = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  lock,
    output logic [GNT_W-1:0] gnt,
    output logic [NREQ-1:0]  gnt_oh,
    output logic             gnt_vld,
    output logic             gnt_chg
);

    localparam int HC_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = (HOLD_MAX > 0) ? HC_W'(HOLD_MAX - 1) : '0;

    if (NREQ < 2 || NREQ > WB_ARB_MAX_REQ || HOLD_MAX < 0 || HOLD_MAX > 255) begin : g_bad_param
        $error("wb_arb_rr: NREQ must be 2..16 and HOLD_MAX 0..255");
    end

    logic [HC_W-1:0]  hold_cnt;
    logic [HC_W-1:0]  nxt_cnt;
    logic [NREQ-1:0]  cur_oh;
    logic [NREQ-1:0]  others;
    logic             cur_lock;
    logic [GNT_W-1:0] start;
    logic [GNT_W-1:0] sel;
    logic [GNT_W-1:0] nxt_gnt;
    logic             found;

    wb_arb_pick #(.NREQ(NREQ)) u_pick (
        .req_mask (others),
        .start    (start),
        .mode     (ARB_MODE),
        .found    (found),
        .idx      (sel)
    );

    // The bus belongs to master gnt only while gnt_vld is high; a parked grant is not a grant.
    always_comb begin
        cur_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            cur_oh[i] = (gnt == GNT_W'(i));
        end
        gnt_vld  = |(req & cur_oh);
        cur_lock = |(lock & cur_oh);
        others   = req & ~cur_oh;
        gnt_oh   = cur_oh & {NREQ{gnt_vld}};
        start    = (gnt == GNT_W'(NREQ - 1)) ? '0 : gnt + GNT_W'(1);
    end

    always_comb begin
        nxt_gnt = gnt;
        if (found && !gnt_vld) begin
            nxt_gnt = sel;
        end else if (found && gnt_vld && (HOLD_MAX > 0) && (hold_cnt == HOLD_LAST) && !cur_lock) begin
            nxt_gnt = sel;
        end

        // Counts cycles the holder keeps the bus while someone else is waiting.
        if ((HOLD_MAX == 0) || (nxt_gnt != gnt) || !gnt_vld) begin
            nxt_cnt = '0;
        end else if (found && !cur_lock && (hold_cnt != HOLD_LAST)) begin
            nxt_cnt = hold_cnt + HC_W'(1);
        end else begin
            nxt_cnt = hold_cnt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt      <= '0;
            hold_cnt <= '0;
            gnt_chg  <= 1'b0;
        end else begin
            gnt      <= nxt_gnt;
            hold_cnt <= nxt_cnt;
            gnt_chg  <= (nxt_gnt != gnt);
        end
    end

endmodule

// File: tb/tb_wb_arb_rr.sv
// Bench for wb_arb_rr: four instances (RR, fixed, hold-limited N=3, N=5 wrap) driven together,
// with a behavioural model feeding an expected queue that a monitor drains every cycle.
module tb_wb_arb_rr;
    import wb_arb_pkg::*;

    localparam int NI = 4;
    localparam int EW = 22;
    localparam int W  = NI * EW;

    logic        clk;
    logic        rstn;
    logic [15:0] req_v  [NI];
    logic [15:0] lock_v [NI];
    logic [3:0]  gnt_w  [NI];
    logic [15:0] oh_w   [NI];
    logic        vld_w  [NI];
    logic        chg_w  [NI];

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int m_gnt [NI];
    int m_cnt [NI];

    function automatic int cfg_n(input int c);
        case (c)
            2:       return 3;
            3:       return 5;
            default: return 4;
        endcase
    endfunction

    function automatic logic cfg_mode(input int c);
        return (c == 1) ? ARB_MODE_FIXED : ARB_MODE_RR;
    endfunction

    function automatic int cfg_hold(input int c);
        case (c)
            2:       return 4;
            3:       return 6;
            default: return 0;
        endcase
    endfunction

    for (genvar c = 0; c < NI; c++) begin : g_dut
        localparam int   N    = cfg_n(c);
        localparam logic MODE = cfg_mode(c);
        localparam int   HM   = cfg_hold(c);
        logic [$clog2(N)-1:0] g;
        logic [N-1:0]         oh;
        logic                 v;
        logic                 ch;

        wb_arb_rr #(.NREQ(N), .ARB_MODE(MODE), .HOLD_MAX(HM)) u_dut (
            .clk     (clk),
            .rstn    (rstn),
            .req     (req_v[c][N-1:0]),
            .lock    (lock_v[c][N-1:0]),
            .gnt     (g),
            .gnt_oh  (oh),
            .gnt_vld (v),
            .gnt_chg (ch)
        );

        assign gnt_w[c] = 4'(g);
        assign oh_w[c]  = 16'(oh);
        assign vld_w[c] = v;
        assign chg_w[c] = ch;
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NI; c++) begin
            m_gnt[c] = 0;
            m_cnt[c] = 0;
        end
    endtask

    // Reference: one clock edge of the arbitration rules, on plain integers.
    task automatic model_step(input int c, output logic [EW-1:0] e);
        int   n, hm, g, pick, ng;
        logic holder, chg, vld;
        n      = cfg_n(c);
        hm     = cfg_hold(c);
        g      = m_gnt[c];
        holder = req_v[c][g];
        pick   = -1;
        if (cfg_mode(c) == ARB_MODE_RR) begin
            for (int k = 1; k < n; k++) begin
                if (pick < 0 && req_v[c][(g + k) % n]) pick = (g + k) % n;
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                if (pick < 0 && i != g && req_v[c][i]) pick = i;
            end
        end
        ng = g;
        if (!holder && pick >= 0) begin
            ng = pick;
        end else if (holder && hm > 0 && m_cnt[c] == hm - 1 && !lock_v[c][g] && pick >= 0) begin
            ng = pick;
        end
        if (ng != g || !holder || hm == 0) begin
            m_cnt[c] = 0;
        end else if (pick >= 0 && !lock_v[c][g]) begin
            m_cnt[c] = (m_cnt[c] + 1 > hm - 1) ? hm - 1 : m_cnt[c] + 1;
        end
        chg      = (ng != g);
        m_gnt[c] = ng;
        vld      = req_v[c][ng];
        e = {4'(ng), 16'(vld ? (1 << ng) : 0), vld, chg};
    endtask

    // driver tasks
    task automatic set_req(input int c, input logic [15:0] r, input logic [15:0] l);
        logic [15:0] m;
        m         = 16'((32'd1 << cfg_n(c)) - 1);
        req_v[c]  = r & m;
        lock_v[c] = l & m;
    endtask

    task automatic step();
        logic [W-1:0]  w;
        logic [EW-1:0] e;
        w = '0;
        for (int c = 0; c < NI; c++) begin
            model_step(c, e);
            w[c*EW +: EW] = e;
        end
        exp_q.push_back(w);
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        for (int c = 0; c < NI; c++) begin
            check($sformatf("%s i%0d gnt", tag, c), int'(gnt_w[c]), 0);
            check($sformatf("%s i%0d gnt_chg", tag, c), int'(chg_w[c]), 0);
            check($sformatf("%s i%0d gnt_vld", tag, c), int'(vld_w[c]), int'(req_v[c][0]));
            check($sformatf("%s i%0d gnt_oh", tag, c), int'(oh_w[c]), int'(req_v[c][0]));
        end
    endtask

    // scoreboard monitor
    initial begin
        logic [W-1:0]  w;
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                for (int c = 0; c < NI; c++) begin
                    e = w[c*EW +: EW];
                    check($sformatf("i%0d gnt", c), int'(gnt_w[c]), int'(e[21:18]));
                    check($sformatf("i%0d gnt_oh", c), int'(oh_w[c]), int'(e[17:2]));
                    check($sformatf("i%0d gnt_vld", c), int'(vld_w[c]), int'(e[1]));
                    check($sformatf("i%0d gnt_chg", c), int'(chg_w[c]), int'(e[0]));
                    check($sformatf("i%0d gnt range", c), int'(int'(gnt_w[c]) < cfg_n(c)), 1);
                end
            end
        end
    end

    initial begin
        logic [15:0] r, l;
        rstn = 1'b1;
        for (int c = 0; c < NI; c++) set_req(c, 16'h0, 16'h0);
        model_reset();
        #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outs("reset");
        rstn = 1'b1;

        // parked with no requests
        repeat (10) step();
        for (int c = 0; c < NI; c++) check($sformatf("park i%0d gnt", c), int'(gnt_w[c]), 0);

        // round robin rotation on instance 0
        set_req(0, 16'b0010, 16'h0); step();
        set_req(0, 16'b1111, 16'h0); step(); step();
        check("rr hold gnt", int'(gnt_w[0]), 1);
        set_req(0, 16'b1101, 16'h0); step();
        check("rr 1->2", int'(gnt_w[0]), 2);
        check("rr chg pulse", int'(chg_w[0]), 1);
        step();
        check("rr chg single", int'(chg_w[0]), 0);
        set_req(0, 16'b1001, 16'h0); step();
        check("rr 2->3", int'(gnt_w[0]), 3);
        set_req(0, 16'b0001, 16'h0); step();
        check("rr 3->0", int'(gnt_w[0]), 0);
        set_req(0, 16'h0, 16'h0); step();

        // fixed priority on instance 1
        set_req(1, 16'b1000, 16'h0); step();
        check("fixed take 3", int'(gnt_w[1]), 3);
        set_req(1, 16'b1110, 16'h0); step(); step();
        check("fixed hold 3", int'(gnt_w[1]), 3);
        set_req(1, 16'b0110, 16'h0); step();
        check("fixed lowest", int'(gnt_w[1]), 1);
        set_req(1, 16'h0, 16'h0); step();

        // hold limit and lock on instance 2 (N=3, HOLD_MAX=4)
        set_req(2, 16'b101, 16'h0);
        repeat (3) step();
        check("hold before limit", int'(gnt_w[2]), 0);
        step();
        check("hold preempt", int'(gnt_w[2]), 2);
        set_req(2, 16'b001, 16'h0); step();
        check("hold back to 0", int'(gnt_w[2]), 0);
        set_req(2, 16'b101, 16'b001);
        repeat (20) step();
        check("lock keeps grant", int'(gnt_w[2]), 0);
        set_req(2, 16'b101, 16'h0);
        repeat (3) step();
        check("count to saturation", int'(gnt_w[2]), 0);
        set_req(2, 16'b101, 16'b001);
        repeat (2) step();
        check("lock at saturation", int'(gnt_w[2]), 0);
        set_req(2, 16'b101, 16'h0); step();
        check("unlock preempt", int'(gnt_w[2]), 2);
        set_req(2, 16'h0, 16'h0); step();

        // non power-of-two wrap on instance 3 (N=5)
        set_req(3, 16'b10000, 16'h0); step();
        check("np take 4", int'(gnt_w[3]), 4);
        set_req(3, 16'b10011, 16'h0); step();
        check("np hold 4", int'(gnt_w[3]), 4);
        set_req(3, 16'b00011, 16'h0); step();
        check("np wrap to 0", int'(gnt_w[3]), 0);

        // mid-operation asynchronous reset
        set_req(3, 16'b00100, 16'h0); step();
        check("mid take 2", int'(gnt_w[3]), 2);
        set_req(3, 16'b00101, 16'h0);
        repeat (2) step();
        set_req(0, 16'b0100, 16'h0); step();
        check("mid still 2", int'(gnt_w[3]), 2);
        check("mid i0 chg before", int'(chg_w[0]), 1);
        rstn = 1'b0;
        #1;
        chk_reset_outs("mid reset");
        rstn = 1'b1;
        model_reset();
        set_req(3, 16'b00100, 16'h0); step();
        check("resume i3", int'(gnt_w[3]), 2);
        check("resume i0", int'(gnt_w[0]), 2);
        for (int c = 0; c < NI; c++) set_req(c, 16'h0, 16'h0);
        step();

        // randomized traffic with occasional asynchronous reset pulses
        repeat (10000) begin
            if ($urandom_range(0, 499) == 0) begin
                rstn = 1'b0;
                #1 rstn = 1'b1;
                model_reset();
            end
            for (int c = 0; c < NI; c++) begin
                r = req_v[c] ^ (16'($urandom) & 16'($urandom));
                l = 16'($urandom) & 16'($urandom) & 16'($urandom);
                set_req(c, r, l);
            end
            step();
        end

        check("queue drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
